// File: rtl/display_pkg.sv
// Shared encodings for the multiplexed 7-segment display path.
package display_pkg;
    localparam int          DIGITS    = 6;
    localparam logic [7:0]  SEG_BLANK = 8'h00;

    localparam logic [1:0]  PG_TIME   = 2'd0;
    localparam logic [1:0]  PG_DATE   = 2'd1;
    localparam logic [1:0]  PG_ALARM  = 2'd2;

    function automatic logic [1:0] next_page(input logic [1:0] p);
        case (p)
            PG_TIME: next_page = PG_DATE;
            PG_DATE: next_page = PG_ALARM;
            default: next_page = PG_TIME;
        endcase
    endfunction
endpackage

// File: rtl/scan_counter.sv
// Digit-slot prescaler and digit index for the six-digit scan.
module scan_counter
    import display_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    output logic [2:0] o_index,
    output logic       o_slot_blank,
    output logic       o_frame_wrap
);
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] r_pre;
    logic [2:0]    r_idx;
    logic          w_tc;

    assign w_tc         = (r_pre == PW'(SCAN_DIV - 1));
    assign o_index      = r_idx;
    assign o_slot_blank = (r_pre < PW'(BLANK_CYC));
    assign o_frame_wrap = w_tc && (r_idx == 3'(DIGITS - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (w_tc) begin
            r_pre <= '0;
            r_idx <= (r_idx == 3'(DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end
endmodule

// File: rtl/display_page_scheduler.sv
// Page selection, idle auto-return, edit blink and registered segment/digit drive
// for the six-digit multiplexed display.
module display_page_scheduler
    import display_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16,
    parameter int TIMEOUT   = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mode_btn,
    input  logic        i_sec_tick,
    input  logic        i_edit_en,
    input  logic [1:0]  i_edit_field,
    input  logic        i_meridian,
    input  logic [47:0] i_time_segs,
    input  logic [47:0] i_date_segs,
    input  logic [47:0] i_alarm_segs,
    output logic [5:0]  o_digit_sel,
    output logic [7:0]  o_seg,
    output logic [1:0]  o_page
);
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [1:0]    r_pend, r_page;
    logic [IW-1:0] r_idle;
    logic          r_blink;
    logic [5:0]    r_digit_sel;
    logic [7:0]    r_seg;

    logic [2:0]    w_idx;
    logic          w_slot_blank, w_frame_wrap, w_accept, w_blanked;
    logic [47:0]   w_src;
    logic [7:0]    w_byte, w_seg;

    scan_counter #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) u_scan (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .o_index      (w_idx),
        .o_slot_blank (w_slot_blank),
        .o_frame_wrap (w_frame_wrap)
    );

    assign w_accept = i_mode_btn && !i_edit_en;

    always_comb begin
        w_src = i_time_segs;
        if (r_page == PG_DATE)       w_src = i_date_segs;
        else if (r_page == PG_ALARM) w_src = i_alarm_segs;
        case (w_idx)
            3'd1:    w_byte = w_src[39:32];
            3'd2:    w_byte = w_src[31:24];
            3'd3:    w_byte = w_src[23:16];
            3'd4:    w_byte = w_src[15:8];
            3'd5:    w_byte = w_src[7:0];
            default: w_byte = w_src[47:40];
        endcase
    end

    // Digit pairs map to edit fields by index/2; field 3 never matches.
    assign w_blanked = r_blink && (i_edit_field != 2'd3) && (i_edit_field == w_idx[2:1]);
    assign w_seg = w_blanked ? SEG_BLANK
                 : (w_byte | {(i_meridian && r_page == PG_TIME && w_idx == 3'd1), 7'b0});

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend      <= PG_TIME;
            r_page      <= PG_TIME;
            r_idle      <= '0;
            r_blink     <= 1'b0;
            r_digit_sel <= '0;
            r_seg       <= SEG_BLANK;
        end else begin
            if (w_accept) begin
                r_pend <= next_page(r_pend);
                r_idle <= '0;
            end else if (r_pend == PG_TIME || i_edit_en) begin
                r_idle <= '0;
            end else if (i_sec_tick) begin
                if (r_idle == IW'(TIMEOUT - 1)) begin
                    r_pend <= PG_TIME;
                    r_idle <= '0;
                end else begin
                    r_idle <= r_idle + IW'(1);
                end
            end
            // Page only changes between frames so one frame never mixes sources.
            if (w_frame_wrap) r_page <= r_pend;
            r_blink     <= i_edit_en && (r_blink ^ i_sec_tick);
            r_digit_sel <= w_slot_blank ? 6'd0 : (6'd1 << w_idx);
            r_seg       <= w_seg;
        end
    end

    assign o_digit_sel = r_digit_sel;
    assign o_seg       = r_seg;
    assign o_page      = r_page;
endmodule

// File: tb/tb_display_page_scheduler.sv
// Randomized scoreboard bench: a cycle-count based reference model predicts each
// registered output; a negedge monitor pops predictions and compares.
module tb_display_page_scheduler;
    localparam int SD = 4;
    localparam int BC = 1;
    localparam int TO = 3;
    localparam int NCYC = 6000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn = 1'b0, tick = 1'b0, edit = 1'b0, mer = 1'b0;
    logic [1:0]  ef = 2'd3;
    logic [47:0] tsegs = 48'h3F0666_5B4F66, dsegs = 48'h6D7D07_7F6F77, asegs = 48'h7C3958_5E7971;
    logic [5:0]  dsel;
    logic [7:0]  seg;
    logic [1:0]  page;

    typedef struct {
        logic [5:0] sel;
        logic [7:0] seg;
        logic [1:0] page;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0, n_bad = 0;

    // Reference model state
    int t = 0, m_pend = 0, m_page = 0, m_idle = 0;
    bit m_blink = 0;

    always #5 clk = ~clk;

    display_page_scheduler #(.SCAN_DIV(SD), .BLANK_CYC(BC), .TIMEOUT(TO)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_mode_btn   (btn),
        .i_sec_tick   (tick),
        .i_edit_en    (edit),
        .i_edit_field (ef),
        .i_meridian   (mer),
        .i_time_segs  (tsegs),
        .i_date_segs  (dsegs),
        .i_alarm_segs (asegs),
        .o_digit_sel  (dsel),
        .o_seg        (seg),
        .o_page       (page)
    );

    always @(posedge clk) begin
        exp_t        e;
        int          pre, idx;
        logic [47:0] src;
        logic [7:0]  b;
        if (rst) begin
            t = 0; m_pend = 0; m_page = 0; m_idle = 0; m_blink = 0;
            e.sel = 6'd0; e.seg = 8'd0; e.page = 2'd0;
        end else begin
            pre = t % SD;
            idx = (t / SD) % 6;
            src = (m_page == 0) ? tsegs : (m_page == 1) ? dsegs : asegs;
            b = src[47 - 8*idx -: 8];
            if (m_blink && ef != 2'd3 && (idx / 2) == int'(ef)) b = 8'h00;
            else if (m_page == 0 && idx == 1 && mer) b[7] = 1'b1;
            e.seg = b;
            e.sel = (pre < BC) ? 6'd0 : 6'(1 << idx);
            if (pre == SD - 1 && idx == 5) m_page = m_pend;
            e.page = 2'(m_page);
            if (btn && !edit) begin
                m_pend = (m_pend + 1) % 3;
                m_idle = 0;
            end else if (m_pend == 0 || edit) begin
                m_idle = 0;
            end else if (tick) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_pend = 0;
                    m_idle = 0;
                end
            end
            m_blink = edit ? (m_blink ^ tick) : 1'b0;
            t++;
        end
        q.push_back(e);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("digit_sel", int'(dsel), int'(e.sel));
            check("seg",       int'(seg),  int'(e.seg));
            check("page",      int'(page), int'(e.page));
        end
    end

    initial begin
        logic [63:0] r64;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            rst  = ($urandom_range(0, 699) == 0);
            btn  = ($urandom_range(0, 59) == 0);
            tick = ($urandom_range(0, 7) == 0);
            if (c > 300 && $urandom_range(0, 79) == 0) edit = ~edit;
            if ($urandom_range(0, 29) == 0) ef = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) mer = ~mer;
            if ($urandom_range(0, 49) == 0) begin
                r64 = {$urandom, $urandom}; tsegs = r64[47:0];
                r64 = {$urandom, $urandom}; dsegs = r64[47:0];
                r64 = {$urandom, $urandom}; asegs = r64[47:0];
                if ($urandom_range(0, 1) == 1) tsegs[39:32] = 8'h06;
            end
        end
        @(posedge clk);
        #1 btn = 1'b0; tick = 1'b0; rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1 check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
